// File: rtl/rv32_cmp_pkg.sv
// Shared definitions for the rv32 comparator arbiter: comparator opsel codes and requester ids.
package rv32_cmp_pkg;

    localparam logic [3:0] OP_SLT   = 4'd5;
    localparam logic [3:0] OP_SLTU  = 4'd6;
    localparam logic [3:0] OP_SLTI  = 4'd12;
    localparam logic [3:0] OP_SLTIU = 4'd13;

    typedef enum logic {
        OWN_ALU = 1'b0,
        OWN_BR  = 1'b1
    } cmp_owner_t;

    // Branch less-than resolution reuses the register-register compare encodings.
    function automatic logic [3:0] br_opsel(input logic is_unsigned);
        return is_unsigned ? OP_SLTU : OP_SLT;
    endfunction

endpackage

// File: rtl/rv32_rr_arb2.sv
// Two-way round-robin grant between ALU and branch requesters; the last winner loses the next tie.
module rv32_rr_arb2
    import rv32_cmp_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inhibit,
    input  logic       req_alu,
    input  logic       req_br,
    input  logic       upd_en,
    input  cmp_owner_t upd_owner,
    output logic       gnt_alu,
    output logic       gnt_br
);

    cmp_owner_t last_grant_r;
    logic       gnt_alu_s;
    logic       gnt_br_s;

    // Grant decode: inhibit wins, a lone requester wins, a tie goes to the one not granted last.
    always_comb begin
        gnt_alu_s = 1'b0;
        gnt_br_s  = 1'b0;
        if (inhibit) begin
            gnt_alu_s = 1'b0;
            gnt_br_s  = 1'b0;
        end else if (req_alu && req_br) begin
            if (last_grant_r == OWN_BR) begin
                gnt_alu_s = 1'b1;
            end else begin
                gnt_br_s = 1'b1;
            end
        end else begin
            gnt_alu_s = req_alu;
            gnt_br_s  = req_br;
        end
    end

    // Fairness history, moved only by a real accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_r <= OWN_BR;
        end else if (upd_en) begin
            last_grant_r <= upd_owner;
        end else begin
            last_grant_r <= last_grant_r;
        end
    end

    assign gnt_alu = gnt_alu_s;
    assign gnt_br  = gnt_br_s;

endmodule

// File: rtl/rv32_cmp_arbiter.sv
// Shares one rv32 comparator between the ALU and branch unit via a 2-stage pipeline.
// Optional RV32_CMP_ARB_PERF_EN adds grant/conflict performance counters.
module rv32_cmp_arbiter
    import rv32_cmp_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            alu_req_valid,
    output logic            alu_req_ready,
    input  logic [XLEN-1:0] alu_opA,
    input  logic [XLEN-1:0] alu_opB,
    input  logic [3:0]      alu_opsel,
    output logic            alu_rsp_valid,
    output logic [XLEN-1:0] alu_rsp_result,
    input  logic            br_req_valid,
    output logic            br_req_ready,
    input  logic [XLEN-1:0] br_opA,
    input  logic [XLEN-1:0] br_opB,
    input  logic            br_unsigned,
    output logic            br_rsp_valid,
    output logic            br_rsp_lt,
    output logic [XLEN-1:0] cmp_opA,
    output logic [XLEN-1:0] cmp_opB,
    output logic [3:0]      cmp_opsel,
    input  logic [XLEN-1:0] cmp_result
`ifdef RV32_CMP_ARB_PERF_EN
    ,
    output logic [31:0]     perf_alu_grants,
    output logic [31:0]     perf_br_grants,
    output logic [31:0]     perf_conflicts
`endif
);

    logic            inhibit_s;
    logic            alu_gnt_s;
    logic            br_gnt_s;
    logic            accept_s;
    cmp_owner_t      acc_owner_s;
    logic [XLEN-1:0] acc_opa_s;
    logic [XLEN-1:0] acc_opb_s;
    logic [3:0]      acc_sel_s;

    logic            s1_valid_r;
    cmp_owner_t      s1_owner_r;
    logic [XLEN-1:0] cmp_opa_r;
    logic [XLEN-1:0] cmp_opb_r;
    logic [3:0]      cmp_sel_r;

    logic            s2_valid_r;
    cmp_owner_t      s2_owner_r;
    logic [XLEN-1:0] alu_result_r;
    logic            br_lt_r;
    logic            s1_live_s;

    assign inhibit_s = flush | rst;
    assign accept_s  = alu_gnt_s | br_gnt_s;
    assign s1_live_s = s1_valid_r & ~flush;

    rv32_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .inhibit   (inhibit_s),
        .req_alu   (alu_req_valid),
        .req_br    (br_req_valid),
        .upd_en    (accept_s),
        .upd_owner (acc_owner_s),
        .gnt_alu   (alu_gnt_s),
        .gnt_br    (br_gnt_s)
    );

    // Operand mux for whichever requester was granted this cycle.
    always_comb begin
        acc_owner_s = OWN_ALU;
        acc_opa_s   = alu_opA;
        acc_opb_s   = alu_opB;
        acc_sel_s   = alu_opsel;
        if (br_gnt_s) begin
            acc_owner_s = OWN_BR;
            acc_opa_s   = br_opA;
            acc_opb_s   = br_opB;
            acc_sel_s   = br_opsel(br_unsigned);
        end else begin
            acc_owner_s = OWN_ALU;
            acc_opa_s   = alu_opA;
            acc_opb_s   = alu_opB;
            acc_sel_s   = alu_opsel;
        end
    end

    // S1: comparator operand registers; they hold when idle so the comparator inputs stay quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_owner_r <= OWN_ALU;
            cmp_opa_r  <= {XLEN{1'b0}};
            cmp_opb_r  <= {XLEN{1'b0}};
            cmp_sel_r  <= 4'd0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_owner_r <= acc_owner_s;
                cmp_opa_r  <= acc_opa_s;
                cmp_opb_r  <= acc_opb_s;
                cmp_sel_r  <= acc_sel_s;
            end else begin
                s1_owner_r <= s1_owner_r;
                cmp_opa_r  <= cmp_opa_r;
                cmp_opb_r  <= cmp_opb_r;
                cmp_sel_r  <= cmp_sel_r;
            end
        end
    end

    // S2: capture comparator result into the owner's result register; the other owner's value holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r   <= 1'b0;
            s2_owner_r   <= OWN_ALU;
            alu_result_r <= {XLEN{1'b0}};
            br_lt_r      <= 1'b0;
        end else begin
            s2_valid_r <= s1_live_s;
            s2_owner_r <= s1_owner_r;
            if (s1_live_s && (s1_owner_r == OWN_ALU)) begin
                alu_result_r <= cmp_result;
                br_lt_r      <= br_lt_r;
            end else if (s1_live_s && (s1_owner_r == OWN_BR)) begin
                alu_result_r <= alu_result_r;
                br_lt_r      <= cmp_result[0];
            end else begin
                alu_result_r <= alu_result_r;
                br_lt_r      <= br_lt_r;
            end
        end
    end

`ifdef RV32_CMP_ARB_PERF_EN
    logic [31:0] perf_alu_r;
    logic [31:0] perf_br_r;
    logic [31:0] perf_conf_r;

    // Event counters survive flush and wrap naturally at 2^32.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_alu_r  <= 32'd0;
            perf_br_r   <= 32'd0;
            perf_conf_r <= 32'd0;
        end else begin
            perf_alu_r  <= perf_alu_r + {31'd0, alu_gnt_s};
            perf_br_r   <= perf_br_r + {31'd0, br_gnt_s};
            perf_conf_r <= perf_conf_r + {31'd0, (alu_req_valid & br_req_valid & ~flush)};
        end
    end

    assign perf_alu_grants = perf_alu_r;
    assign perf_br_grants  = perf_br_r;
    assign perf_conflicts  = perf_conf_r;
`endif

    assign alu_req_ready  = alu_gnt_s;
    assign br_req_ready   = br_gnt_s;
    assign cmp_opA        = cmp_opa_r;
    assign cmp_opB        = cmp_opb_r;
    assign cmp_opsel      = cmp_sel_r;
    assign alu_rsp_valid  = s2_valid_r & (s2_owner_r == OWN_ALU);
    assign br_rsp_valid   = s2_valid_r & (s2_owner_r == OWN_BR);
    assign alu_rsp_result = alu_result_r;
    assign br_rsp_lt      = br_lt_r;

endmodule

// File: tb/tb_rv32_cmp_arbiter.sv
// Scoreboard bench for rv32_cmp_arbiter: a behavioural comparator feeds the DUT and a cycle model checks grants and responses.
module tb_rv32_cmp_arbiter;
    import rv32_cmp_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush;
    logic        alu_req_valid, alu_req_ready, alu_rsp_valid;
    logic [31:0] alu_opA, alu_opB, alu_rsp_result;
    logic [3:0]  alu_opsel;
    logic        br_req_valid, br_req_ready, br_unsigned, br_rsp_valid, br_rsp_lt;
    logic [31:0] br_opA, br_opB;
    logic [31:0] cmp_opA, cmp_opB, cmp_result;
    logic [3:0]  cmp_opsel;
`ifdef RV32_CMP_ARB_PERF_EN
    logic [31:0] perf_alu_grants, perf_br_grants, perf_conflicts;
    logic [31:0] m_pa = 32'd0, m_pb = 32'd0, m_pc = 32'd0;
`endif

    always #5 clk = ~clk;

    rv32_cmp_arbiter #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .alu_req_valid(alu_req_valid), .alu_req_ready(alu_req_ready),
        .alu_opA(alu_opA), .alu_opB(alu_opB), .alu_opsel(alu_opsel),
        .alu_rsp_valid(alu_rsp_valid), .alu_rsp_result(alu_rsp_result),
        .br_req_valid(br_req_valid), .br_req_ready(br_req_ready),
        .br_opA(br_opA), .br_opB(br_opB), .br_unsigned(br_unsigned),
        .br_rsp_valid(br_rsp_valid), .br_rsp_lt(br_rsp_lt),
        .cmp_opA(cmp_opA), .cmp_opB(cmp_opB), .cmp_opsel(cmp_opsel),
        .cmp_result(cmp_result)
`ifdef RV32_CMP_ARB_PERF_EN
        , .perf_alu_grants(perf_alu_grants), .perf_br_grants(perf_br_grants),
        .perf_conflicts(perf_conflicts)
`endif
    );

    // Behavioural comparator: only the four set-less-than encodings produce a nonzero result.
    function automatic logic [31:0] cmp_fn(input logic [31:0] a, input logic [31:0] b, input logic [3:0] sel);
        case (sel)
            4'd5, 4'd12: return {31'd0, ($signed(a) < $signed(b))};
            4'd6, 4'd13: return {31'd0, (a < b)};
            default:     return 32'd0;
        endcase
    endfunction

    assign cmp_result = cmp_fn(cmp_opA, cmp_opB, cmp_opsel);

    typedef struct {
        int          due;
        bit          is_br;
        logic [31:0] res;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    bit          last_br = 1'b1;
    logic [31:0] m_opa = 32'd0, m_opb = 32'd0, held_alu = 32'd0;
    logic [3:0]  m_sel = 4'd0;
    logic        held_br = 1'b0;
    logic        e_av, e_bv, e_ar, e_br, inh;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Per-cycle model: check responses, operand registers and grants, then advance model state.
    always @(negedge clk) begin
        e_av = 1'b0;
        e_bv = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            if (sb[0].is_br) begin
                e_bv    = 1'b1;
                held_br = sb[0].res[0];
            end else begin
                e_av     = 1'b1;
                held_alu = sb[0].res;
            end
            void'(sb.pop_front());
        end
        check_eq("alu_rsp_valid", {31'd0, alu_rsp_valid}, {31'd0, e_av});
        check_eq("br_rsp_valid", {31'd0, br_rsp_valid}, {31'd0, e_bv});
        check_eq("alu_rsp_result", alu_rsp_result, held_alu);
        check_eq("br_rsp_lt", {31'd0, br_rsp_lt}, {31'd0, held_br});
        check_eq("cmp_opA", cmp_opA, m_opa);
        check_eq("cmp_opB", cmp_opB, m_opb);
        check_eq("cmp_opsel", {28'd0, cmp_opsel}, {28'd0, m_sel});

        inh  = flush | rst;
        e_ar = !inh && alu_req_valid && (!br_req_valid || last_br);
        e_br = !inh && br_req_valid && (!alu_req_valid || !last_br);
        check_eq("alu_req_ready", {31'd0, alu_req_ready}, {31'd0, e_ar});
        check_eq("br_req_ready", {31'd0, br_req_ready}, {31'd0, e_br});
        check_eq("one_ready", {31'd0, alu_req_ready & br_req_ready}, 32'd0);
`ifdef RV32_CMP_ARB_PERF_EN
        check_eq("perf_alu", perf_alu_grants, m_pa);
        check_eq("perf_br", perf_br_grants, m_pb);
        check_eq("perf_conf", perf_conflicts, m_pc);
        if (e_ar) m_pa = m_pa + 32'd1;
        if (e_br) m_pb = m_pb + 32'd1;
        if (alu_req_valid && br_req_valid && !flush) m_pc = m_pc + 32'd1;
        if (rst) begin m_pa = 32'd0; m_pb = 32'd0; m_pc = 32'd0; end
`endif

        if (e_ar) begin
            sb.push_back('{due: cyc + 2, is_br: 1'b0, res: cmp_fn(alu_opA, alu_opB, alu_opsel)});
            m_opa = alu_opA; m_opb = alu_opB; m_sel = alu_opsel; last_br = 1'b0;
        end else if (e_br) begin
            sb.push_back('{due: cyc + 2, is_br: 1'b1,
                           res: {31'd0, br_unsigned ? (br_opA < br_opB) : ($signed(br_opA) < $signed(br_opB))}});
            m_opa = br_opA; m_opb = br_opB; m_sel = br_unsigned ? 4'd6 : 4'd5; last_br = 1'b1;
        end
        if (inh) begin
            for (int k = sb.size() - 1; k >= 0; k--) begin
                if (sb[k].due == cyc + 1) sb.delete(k);
            end
        end
        if (rst) begin
            held_alu = 32'd0; held_br = 1'b0; m_opa = 32'd0; m_opb = 32'd0; m_sel = 4'd0; last_br = 1'b1;
        end
    end

    task automatic drive(input logic av, input logic [31:0] aa, input logic [31:0] ab, input logic [3:0] as,
                         input logic bv, input logic [31:0] ba, input logic [31:0] bb, input logic bu,
                         input logic fl, input logic rs);
        alu_req_valid = av; alu_opA = aa; alu_opB = ab; alu_opsel = as;
        br_req_valid = bv; br_opA = ba; br_opB = bb; br_unsigned = bu;
        flush = fl; rst = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [3:0] sels [6];
        sels = '{4'd5, 4'd6, 4'd12, 4'd13, 4'd0, 4'd9};

        repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(2);
        // ALU signed then unsigned compare of -1 vs 1
        drive(1, 32'hFFFF_FFFF, 32'h1, 4'd5, 0, 0, 0, 0, 0, 0);
        idle(1);
        drive(1, 32'hFFFF_FFFF, 32'h1, 4'd6, 0, 0, 0, 0, 0, 0);
        idle(3);
        // Branch signed then unsigned
        drive(0, 0, 0, 0, 1, 32'h8000_0000, 32'h7FFF_FFFF, 0, 0, 0);
        idle(1);
        drive(0, 0, 0, 0, 1, 32'h8000_0000, 32'h7FFF_FFFF, 1, 0, 0);
        idle(3);
        // Reset, then both requesters held: alternation must start with ALU
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 6; i++)
            drive(1, 32'(i), 32'd3, 4'd5, 1, 32'(10 - i), 32'd7, i[0], 0, 0);
        idle(3);
        // Back-to-back SLTI stream
        for (int i = 0; i < 4; i++) drive(1, 32'd3, 32'(5 + i), 4'd12, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Accept, flush while in S1 with a branch request present, then a fresh accept
        drive(1, 32'd7, 32'd9, 4'd6, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 32'd1, 32'd2, 0, 1, 0);
        drive(1, 32'hFFFF_FFFE, 32'd1, 4'd5, 0, 0, 0, 0, 0, 0);
        idle(4);
        // Reset right after an accept, then a conflict
        drive(1, 32'd1, 32'd2, 4'd5, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        idle(1);
        for (int i = 0; i < 4; i++)
            drive(1, 32'd4, 32'(i), 4'd13, 1, 32'(i), 32'd2, 1, 0, 0);
        idle(3);
        // Random mix with occasional flush
        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 1), $urandom, ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom,
                  sels[$urandom_range(0, 5)],
                  $urandom_range(0, 1), $urandom, $urandom, $urandom_range(0, 1),
                  ($urandom_range(0, 9) == 0), 0);
        end
        idle(5);
        check_eq("scoreboard_drained", sb.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/rv32_cmp_arbiter.md
Name: rv32_cmp_arbiter

Overview:
- Shares the single rv32 signed/unsigned comparator between two requesters: the execute-stage ALU (SLT/SLTU/SLTI/SLTIU) and the branch unit (BLT/BGE/BLTU/BGEU less-than resolution).
- Arbitrates round-robin with valid/ready request handshakes.
- Drives the comparator from registered operands and returns the registered result to whichever requester owns it.
- Fixed two-stage pipeline: one accept per cycle, pipeline flush support.

Parameters:
- XLEN, 32, operand/result width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- flush  in  1  kill all in-flight comparisons (pipeline redirect)
- alu_req_valid  in  1  ALU request valid
- alu_req_ready  out  1  ALU request accepted this cycle
- alu_opA  in  XLEN  ALU operand A
- alu_opB  in  XLEN  ALU operand B (RT or IMM, muxed upstream)
- alu_opsel  in  4  ALU op select, passed to comparator unchanged
- alu_rsp_valid  out  1  ALU result valid (1-cycle pulse)
- alu_rsp_result  out  XLEN  ALU comparison result
- br_req_valid  in  1  branch request valid
- br_req_ready  out  1  branch request accepted this cycle
- br_opA  in  XLEN  branch rs1
- br_opB  in  XLEN  branch rs2
- br_unsigned  in  1  1 = BLTU/BGEU, 0 = BLT/BGE
- br_rsp_valid  out  1  branch result valid (1-cycle pulse)
- br_rsp_lt  out  1  rs1 < rs2 under the selected signedness
- cmp_opA  out  XLEN  to comparator opA
- cmp_opB  out  XLEN  to comparator opB
- cmp_opsel  out  4  to comparator alu_opsel
- cmp_result  in  XLEN  from comparator result (combinational)

Behaviour:
- Clock, reset: single clock clk; reset rst is synchronous and active-high.
- Stage S1 registers: s1_valid, s1_owner (ALU/BR), cmp_opA, cmp_opB, cmp_opsel.
- Stage S2 registers: s2_valid, s2_owner, s2_result.
- Reset values:
  - s1_valid = s2_valid = 0.
  - cmp_opA = cmp_opB = 0; cmp_opsel = 0 (comparator outputs 0).
  - All rsp outputs = 0.
  - last_grant = BR, so the ALU wins the first conflict.
- Grant (combinational, cycle N):
  - If flush or rst, neither ready is asserted.
  - If only one valid, that requester's ready = 1.
  - If both valid, grant the requester not equal to last_grant; the other's ready = 0.
  - No S1 back-pressure: the pipeline always advances, so at most one ready is 1 per cycle.
- Accept at cycle N:
  - S1 loads at N+1 with the granted operands.
  - ALU request: opsel = alu_opsel.
  - BR request: opsel = br_unsigned ? 6 (SLTU) : 5 (SLT).
  - last_grant updates only on an actual accept.
- The comparator evaluates during N+1. S2 captures cmp_result and owner at the end of N+1.
- Response at N+2:
  - alu_rsp_valid or br_rsp_valid = s2_valid for the matching owner.
  - alu_rsp_result = s2_result.
  - br_rsp_lt = s2_result[0].
  - The non-owner result output holds its previous value.
- Latency is 2 cycles from accept to response; throughput is 1 per cycle; responses return in order. The ALU may opsel any value; non-compare opsel yields 0 (comparator behaviour).
- Idle cycle (no accept): s1_valid = 0. cmp_opA/opB/opsel hold their last values (no toggling, to save power).
- Flush (sync):
  - s1_valid and s2_valid clear at the next edge.
  - No response pulses occur in the cycle after flush for ops in flight at flush.
  - Requests presented in the flush cycle are not accepted.
  - last_grant is unchanged.
- Reset mid-operation: identical to flush, plus all registers return to reset values. No response is emitted for in-flight ops.
- Simultaneous accept and S2 response in the same cycle is normal pipelined operation.

Optional Feature:
- Macro: RV32_CMP_ARB_PERF_EN.
- When defined, adds outputs perf_alu_grants[31:0], perf_br_grants[31:0] and perf_conflicts[31:0]:
  - perf_alu_grants: counts ALU accepts.
  - perf_br_grants: counts BR accepts.
  - perf_conflicts: counts cycles with both valid and no flush.
  - All counters reset to 0 on rst, are not cleared by flush, and wrap at 2^32 to 0.
- When undefined, the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package rv32_cmp_pkg holds:
  - Opsel constants OP_SLT=4'd5, OP_SLTU=4'd6, OP_SLTI=4'd12, OP_SLTIU=4'd13.
  - typedef enum logic {OWN_ALU, OWN_BR} cmp_owner_t.
- Sub-module rv32_rr_arb2: 2-way round-robin grant with last_grant register, update-on-accept input and global inhibit (flush/rst).

Test Plan:
- ALU only, opA=32'hFFFFFFFF, opB=32'h1, opsel=5, accept at N -> alu_rsp_valid at N+2, result=1. Same operands with opsel=6 -> result=0.
- BR only, opA=32'h80000000, opB=32'h7FFFFFFF, br_unsigned=0 -> br_rsp_lt=1 at N+2. With br_unsigned=1 -> br_rsp_lt=0; cmp_opsel observed as 5 then 6.
- Both valid and held after reset -> ALU granted at N, BR at N+1, ALU at N+2 (alternating); responses alternate owners from N+2. No accept-cycle has both ready=1.
- Back-to-back ALU stream of 4 ops (opsel 12, opA=3, opB=5..8) -> 4 consecutive alu_rsp_valid pulses, each result=1, in order.
- Accept at N, flush at N+1 -> no rsp pulse at N+2 or N+3. A request at the flush cycle sees ready=0. A request at N+2 responds at N+4.
- rst asserted at N+1 after an accept at N -> no response. All rsp outputs and cmp_opsel are 0 at N+2. After rst, the first conflict is granted to ALU. With RV32_CMP_ARB_PERF_EN, counters read 0.
